// File: rtl/scoreboard_hazard_pkg.sv
// Shared constants and the scoreboard-entry record used by the hazard unit and its entries.
package scoreboard_hazard_pkg;

  localparam int FWD_RF   = 0;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Fields are wide enough for any practical DEPTH; entries zero-extend their FW-bit state.
  localparam int SB_FIELD_W = 8;

  typedef struct packed {
    logic                  pending;
    logic [SB_FIELD_W-1:0] cnt;
    logic [SB_FIELD_W-1:0] age;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_hazard_sb_entry.sv
// One architectural register's scoreboard entry: pending flag, cycles-until-ready and age since issue.
module sb_entry
  import scoreboard_hazard_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic [FW-1:0] lat_i,
  output sb_entry_t     ent_o
);

  logic          pending_p0;
  logic [FW-1:0] cnt_p0;
  logic [FW-1:0] age_p0;

  // A new producer overrides any same-edge decrement or retire of the old one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_p0 <= 1'b0;
      cnt_p0     <= '0;
      age_p0     <= '0;
    end else if (set_i) begin
      pending_p0 <= 1'b1;
      cnt_p0     <= lat_i;
      age_p0     <= '0;
    end else if (pending_p0) begin
      if (age_p0 == FW'(DEPTH - 1)) begin
        pending_p0 <= 1'b0;
        cnt_p0     <= '0;
        age_p0     <= '0;
      end else begin
        cnt_p0 <= (cnt_p0 == '0) ? '0 : cnt_p0 - 1'b1;
        age_p0 <= age_p0 + 1'b1;
      end
    end
  end

  always_comb begin
    ent_o         = '0;
    ent_o.pending = pending_p0;
    ent_o.cnt     = SB_FIELD_W'(cnt_p0);
    ent_o.age     = SB_FIELD_W'(age_p0);
  end

endmodule

// File: rtl/scoreboard_hazard.sv
// Register scoreboard for an in-order pipeline: ID-stage stall detection and EX operand forwarding select.
module scoreboard_hazard
  import scoreboard_hazard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(NREG),
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic          id_rs_used_i,
  input  logic          id_rt_used_i,
  input  logic          id_wr_i,
  input  logic [AW-1:0] id_rd_i,
  input  logic [FW-1:0] id_lat_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          ex_valid_o,
  output logic [FW-1:0] fwd_a_o,
  output logic [FW-1:0] fwd_b_o
);

  localparam int NSLOT = 2 ** AW;

  sb_entry_t     ent [NSLOT];
  sb_entry_t     rs_ent;
  sb_entry_t     rt_ent;
  logic          haz_rs;
  logic          haz_rt;
  logic          issue;
  logic [FW-1:0] lat_eff;
  logic [FW-1:0] fwd_a_nxt;
  logic [FW-1:0] fwd_b_nxt;
  logic          ex_valid_p1;
  logic [FW-1:0] fwd_a_p1;
  logic [FW-1:0] fwd_b_p1;

  function automatic logic src_hazard(input logic used, input logic [AW-1:0] s,
                                      input sb_entry_t e);
    return used && (s != '0) && e.pending && (e.cnt > SB_FIELD_W'(1));
  endfunction

  function automatic logic [FW-1:0] src_fwd(input logic used, input logic [AW-1:0] s,
                                            input sb_entry_t e);
    if (used && (s != '0) && e.pending)
      return FW'(e.age + 1'b1);
    return FW'(FWD_RF);
  endfunction

  assign lat_eff = ((id_lat_i == '0) || (int'(id_lat_i) > DEPTH)) ? FW'(DEPTH) : id_lat_i;

  // Register 0 and any unused address slots are permanently idle.
  for (genvar r = 0; r < NSLOT; r++) begin : g_ent
    if (r == 0 || r >= NREG) begin : g_idle
      assign ent[r] = '0;
    end else begin : g_live
      logic set;
      assign set = issue && id_wr_i && (id_rd_i == AW'(r));
      sb_entry #(.DEPTH(DEPTH)) u_entry (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .set_i (set),
        .lat_i (lat_eff),
        .ent_o (ent[r])
      );
    end
  end

  // ID stage: lookups see the pre-issue scoreboard, so rd==rs/rt uses the older producer.
  assign rs_ent    = ent[id_rs_i];
  assign rt_ent    = ent[id_rt_i];
  assign haz_rs    = src_hazard(id_rs_used_i, id_rs_i, rs_ent);
  assign haz_rt    = src_hazard(id_rt_used_i, id_rt_i, rt_ent);
  assign stall_o   = id_valid_i && !flush_i && (haz_rs || haz_rt);
  assign issue     = id_valid_i && !flush_i && !stall_o;
  assign fwd_a_nxt = src_fwd(id_rs_used_i, id_rs_i, rs_ent);
  assign fwd_b_nxt = src_fwd(id_rt_used_i, id_rt_i, rt_ent);

  // ID -> EX boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_p1 <= 1'b0;
      fwd_a_p1    <= '0;
      fwd_b_p1    <= '0;
    end else begin
      ex_valid_p1 <= issue;
      fwd_a_p1    <= issue ? fwd_a_nxt : FW'(FWD_RF);
      fwd_b_p1    <= issue ? fwd_b_nxt : FW'(FWD_RF);
    end
  end

  assign ex_valid_o = ex_valid_p1;
  assign fwd_a_o    = fwd_a_p1;
  assign fwd_b_o    = fwd_b_p1;

endmodule

// File: tb/tb_scoreboard_hazard.sv
// Scenario bench for scoreboard_hazard (NREG=32, DEPTH=2) with a timestamp-based reference model.
module tb_scoreboard_hazard;
  import scoreboard_hazard_pkg::*;

  localparam int NREG  = 32;
  localparam int DEPTH = 2;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [4:0] rs, rt, rd;
  logic       rs_used, rt_used, wr, flush;
  logic [1:0] lat;
  logic       stall, ex_valid;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int passes = 0;

  // Reference model: each register remembers the edge its newest producer issued on.
  int edge_cnt = 0;
  int wr_edge [NREG];
  int wr_lat  [NREG];
  bit live    [NREG];
  bit e_ex;
  int e_fa, e_fb;

  scoreboard_hazard #(.NREG(NREG), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (valid),
    .id_rs_i      (rs),
    .id_rt_i      (rt),
    .id_rs_used_i (rs_used),
    .id_rt_used_i (rt_used),
    .id_wr_i      (wr),
    .id_rd_i      (rd),
    .id_lat_i     (lat),
    .flush_i      (flush),
    .stall_o      (stall),
    .ex_valid_o   (ex_valid),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_pending(int r);
    return (r != 0) && live[r] && ((edge_cnt - wr_edge[r]) < DEPTH);
  endfunction

  function automatic bit m_haz(int s, bit used);
    int remain;
    if (!used || !m_pending(s)) return 1'b0;
    remain = wr_lat[s] - (edge_cnt - wr_edge[s]);
    return remain > 1;
  endfunction

  function automatic int m_fwd(int s, bit used);
    if (!used || !m_pending(s)) return FWD_RF;
    return edge_cnt - wr_edge[s] + 1;
  endfunction

  function automatic bit m_stall();
    return valid && !flush && (m_haz(int'(rs), rs_used) || m_haz(int'(rt), rt_used));
  endfunction

  task automatic set_in(bit v, int a, int b, bit au, bit bu, bit w, int d, int l, bit fl, bit r);
    valid = v; rs = 5'(a); rt = 5'(b); rs_used = au; rt_used = bu;
    wr = w; rd = 5'(d); lat = 2'(l); flush = fl; rst = r;
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic tick();
    bit iss;
    int l;
    iss  = valid && !flush && !m_stall();
    e_ex = iss;
    e_fa = iss ? m_fwd(int'(rs), rs_used) : 0;
    e_fb = iss ? m_fwd(int'(rt), rt_used) : 0;
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      for (int i = 0; i < NREG; i++) live[i] = 1'b0;
      e_ex = 1'b0; e_fa = 0; e_fb = 0;
    end else if (iss && wr && rd != 0) begin
      l = int'(lat);
      if (l < 1 || l > DEPTH) l = DEPTH;
      wr_edge[rd] = edge_cnt;
      wr_lat[rd]  = l;
      live[rd]    = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    tick();
    nop();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %0b want 0", ex_valid); else passes++;
    checks++; if (fwd_a !== 2'd0) $display("FAIL reset_fwd_a got %0d want 0", fwd_a); else passes++;
    checks++; if (fwd_b !== 2'd0) $display("FAIL reset_fwd_b got %0d want 0", fwd_b); else passes++;
    set_in(1, 1, 2, 1, 1, 1, 3, 1, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else passes++;
    tick();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 1, LAT_ALU, 0, 0);
    tick();
    set_in(1, 1, 0, 1, 1, 1, 2, LAT_ALU, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL alu_stall got %0b want 0", stall); else passes++;
    tick();
    checks++; if (ex_valid !== 1'b1) $display("FAIL alu_ex_valid got %0b want 1", ex_valid); else passes++;
    checks++; if (fwd_a !== 2'd1) $display("FAIL alu_fwd_a got %0d want 1", fwd_a); else passes++;
    checks++; if (fwd_b !== 2'd0) $display("FAIL alu_fwd_b got %0d want 0", fwd_b); else passes++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 1, LAT_LOAD, 0, 0);
    tick();
    set_in(1, 1, 1, 1, 1, 1, 3, LAT_ALU, 0, 0);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL lu_stall got %0b want 1", stall); else passes++;
    tick();
    checks++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_ex got %0b want 0", ex_valid); else passes++;
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) $display("FAIL lu_bubble_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL lu_stall_release got %0b want 0", stall); else passes++;
    tick();
    checks++; if (ex_valid !== 1'b1) $display("FAIL lu_ex_valid got %0b want 1", ex_valid); else passes++;
    checks++; if (fwd_a !== 2'd2) $display("FAIL lu_fwd_a got %0d want 2", fwd_a); else passes++;
    checks++; if (fwd_b !== 2'd2) $display("FAIL lu_fwd_b got %0d want 2", fwd_b); else passes++;
  endtask

  task automatic test_distance();
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 1, LAT_ALU, 0, 0); tick();
    nop(); tick();
    set_in(1, 1, 0, 1, 0, 1, 4, LAT_ALU, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL dist2_stall got %0b want 0", stall); else passes++;
    tick();
    checks++; if (fwd_a !== 2'd2) $display("FAIL dist2_fwd_a got %0d want 2", fwd_a); else passes++;
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 1, LAT_ALU, 0, 0); tick();
    nop(); tick();
    nop(); tick();
    set_in(1, 1, 0, 1, 0, 1, 4, LAT_ALU, 0, 0);
    tick();
    checks++; if (ex_valid !== 1'b1) $display("FAIL dist3_ex_valid got %0b want 1", ex_valid); else passes++;
    checks++; if (fwd_a !== 2'd0) $display("FAIL dist3_fwd_a got %0d want 0", fwd_a); else passes++;
  endtask

  task automatic test_waw();
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 1, LAT_LOAD, 0, 0); tick();
    set_in(1, 0, 0, 0, 0, 1, 1, LAT_ALU, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL waw_second_stall got %0b want 0", stall); else passes++;
    tick();
    set_in(1, 1, 0, 1, 0, 1, 5, LAT_ALU, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL waw_reader_stall got %0b want 0", stall); else passes++;
    tick();
    checks++; if (fwd_a !== 2'd1) $display("FAIL waw_fwd_a got %0d want 1", fwd_a); else passes++;
    set_in(1, 0, 0, 0, 0, 1, 0, LAT_LOAD, 0, 0); tick();
    set_in(1, 0, 0, 1, 1, 1, 6, LAT_ALU, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL r0_stall got %0b want 0", stall); else passes++;
    tick();
    checks++; if (ex_valid !== 1'b1 || fwd_a !== 2'd0 || fwd_b !== 2'd0)
      $display("FAIL r0_ex got v=%0b fa=%0d fb=%0d want v=1 fa=0 fb=0", ex_valid, fwd_a, fwd_b); else passes++;
  endtask

  task automatic test_flush_reset();
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 1, LAT_LOAD, 0, 0); tick();
    set_in(1, 1, 0, 1, 0, 1, 3, LAT_LOAD, 0, 0);
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL flush_pre_stall got %0b want 1", stall); else passes++;
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL flush_stall got %0b want 0", stall); else passes++;
    tick();
    checks++; if (ex_valid !== 1'b0) $display("FAIL flush_ex_valid got %0b want 0", ex_valid); else passes++;
    set_in(1, 3, 0, 1, 0, 1, 6, LAT_ALU, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL flush_nowrite_stall got %0b want 0", stall); else passes++;
    tick();
    checks++; if (fwd_a !== 2'd0) $display("FAIL flush_nowrite_fwd got %0d want 0", fwd_a); else passes++;
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 1, LAT_LOAD, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); tick();
    set_in(1, 1, 0, 1, 0, 1, 2, LAT_ALU, 0, 0);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL rst_mid_stall got %0b want 0", stall); else passes++;
    tick();
    checks++; if (ex_valid !== 1'b1 || fwd_a !== 2'd0)
      $display("FAIL rst_mid_ex got v=%0b fa=%0d want v=1 fa=0", ex_valid, fwd_a); else passes++;
  endtask

  task automatic test_random();
    bit ms;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(3) != 0, $urandom_range(3), $urandom_range(3),
             $urandom_range(1), $urandom_range(1), $urandom_range(3) != 0,
             $urandom_range(3), $urandom_range(3), $urandom_range(7) == 0,
             $urandom_range(59) == 0);
      #1;
      ms = m_stall();
      checks++; if (stall !== ms) $display("FAIL rnd_stall n=%0d got %0b want %0b", n, stall, ms); else passes++;
      tick();
      checks++; if (ex_valid !== e_ex || int'(fwd_a) != e_fa || int'(fwd_b) != e_fb)
        $display("FAIL rnd_ex n=%0d got v=%0b fa=%0d fb=%0d want v=%0b fa=%0d fb=%0d",
                 n, ex_valid, fwd_a, fwd_b, e_ex, e_fa, e_fb);
      else passes++;
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      wr_edge[i] = 0; wr_lat[i] = 0; live[i] = 1'b0;
    end
    nop();
    rst = 1'b1;
    #1;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_distance();
    test_waw();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/scoreboard_hazard.md
SCOREBOARD_HAZARD -- requirements
Module: scoreboard_hazard

Interface
REQ-001 SHALL have parameter NREG, default 32: architectural register count; AW = clog2(NREG).
REQ-002 SHALL have parameter DEPTH, default 2: forwarding pipeline registers after EX (1 = EX/MEM, 2 = MEM/WB, ...); FW = clog2(DEPTH+1).
REQ-003 SHALL have one clock and a synchronous, active-high reset. Ports: clk_i input 1, clock; rst_i input 1, synchronous active-high reset.
REQ-004 SHALL have port id_valid_i, input, 1: the ID stage holds a real instruction.
REQ-005 SHALL have ports id_rs_i and id_rt_i, input, AW each: source register addresses.
REQ-006 SHALL have ports id_rs_used_i and id_rt_used_i, input, 1 each: the corresponding source is actually read.
REQ-007 SHALL have ports id_wr_i (input, 1) and id_rd_i (input, AW): the instruction writes register id_rd_i.
REQ-008 SHALL have port id_lat_i, input, FW: producer latency L, range 1..DEPTH (1 = ALU, 2 = load).
REQ-009 SHALL have port flush_i, input, 1: kill the ID instruction this cycle.
REQ-010 SHALL have port stall_o, output, 1, combinational: hold PC and IF/ID, insert an EX bubble.
REQ-011 SHALL have port ex_valid_o, output, 1, registered: the EX stage holds an issued instruction.
REQ-012 SHALL have ports fwd_a_o and fwd_b_o, output, FW each, registered: EX operand source. 0 = register file; k = pipeline register k.

Function
REQ-013 SHALL keep one entry per register r = 1..NREG-1: pending bit, cnt (FW bits), age (FW bits). Register 0 SHALL never be tracked, never cause a hazard, and always give fwd 0.
REQ-014 SHALL issue on every edge where id_valid_i & !flush_i & !stall_o holds.
REQ-015 On issue with id_wr_i=1 and id_rd_i≠0, SHALL set entry[id_rd_i] to pending=1, cnt=id_lat_i, age=0.
REQ-016 On every edge, each pending entry not being written SHALL decrement cnt (saturating at 0) and increment age.
REQ-017 A pending entry whose age would become DEPTH SHALL clear pending (retire) on that edge.
REQ-018 SHALL compute hazard on source s as: s used & s≠0 & entry[s].pending & entry[s].cnt>1.
REQ-019 stall_o SHALL equal id_valid_i & !flush_i & (hazard on rs | hazard on rt).
REQ-020 On an issue edge, fwd_a_o SHALL load entry[rs].age+1 if rs is used, rs≠0 and pending; otherwise 0. fwd_b_o SHALL load likewise for rt. ex_valid_o SHALL load 1.
REQ-021 On a non-issue edge (stall, flush or invalid), fwd_a_o, fwd_b_o and ex_valid_o SHALL load 0.
REQ-022 SHALL let the newest producer win a WAW on the same register: issue overwrites the entry, and issue takes priority over a same-edge retire or decrement.
REQ-023 When rd matches rs or rt of the same instruction, SHALL use the pre-issue entry for hazard and forwarding.
REQ-024 SHALL treat id_lat_i outside 1..DEPTH as DEPTH.
REQ-025 SHALL not support overlapping latency scheduling; one instruction issues per cycle at most.

Reset
REQ-026 On rst_i=1 at an edge, SHALL clear all pending, cnt and age; fwd_a_o=0, fwd_b_o=0, ex_valid_o=0.
REQ-027 stall_o SHALL read 0 in the cycle following reset.
REQ-028 Reset mid-operation SHALL discard all in-flight producers without retire side-effects.
REQ-029 Reset SHALL take priority over issue.

Structure
REQ-030 SHALL place in a shared package: the fwd encoding constants (FWD_RF=0), the latency constants (LAT_ALU=1, LAT_LOAD=2), and the scoreboard-entry struct typedef.
REQ-031 SHALL implement the per-register entry (pending/cnt/age update) as one sub-module, sb_entry, instantiated NREG-1 times via generate. Hazard and forward selection SHALL live in the top.

Verification (DEPTH=2)
REQ-032 Bench SHALL check ALU producer then consumer: add r1 (L=1); next cycle add r2,r1,r0 -> stall_o 0; consumer EX cycle shows fwd_a_o=1, ex_valid_o=1.
REQ-033 Bench SHALL check load-use: lw r1 (L=2); then add r3,r1,r1 -> stall_o=1 for exactly 1 cycle with one bubble (ex_valid_o=0, fwd=0), then fwd_a_o=fwd_b_o=2.
REQ-034 Bench SHALL check distance: add r1; nop; add r4,r1 -> fwd_a_o=2. add r1; nop; nop; add r4,r1 -> fwd_a_o=0.
REQ-035 Bench SHALL check WAW: lw r1 (L=2); add r1 (L=1); add r5,r1 -> no stall, fwd_a_o=1. Also, an instruction writing r0 followed by a reader of r0 -> no stall, fwd 0.
REQ-036 Bench SHALL check flush and reset: flush_i=1 during a load-use stall -> stall_o=0, next ex_valid_o=0, no entry written. rst_i asserted one cycle after lw r1, then add r2,r1 -> stall_o=0, fwd_a_o=0.
